// File: rtl/cclut_pkg.sv
// Shared definitions for the CCLUT pattern RAM loader: widths, word fields,
// and the loader state encoding.
package cclut_pkg;

  localparam int MXADRB = 12;
  localparam int MXDATB = 9;
  localparam int NPAT   = 5;

  localparam int BEND_LSB = 0;
  localparam int BEND_MSB = 4;
  localparam int OFS_LSB  = 5;
  localparam int OFS_MSB  = 8;

  localparam logic [3:0] OFS_ZERO = 4'd7;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WRITE    = 3'd1,
    ST_READ_ADR = 3'd2,
    ST_READ_CAP = 3'd3,
    ST_CLEAR    = 3'd4
  } state_t;

  function automatic logic [MXDATB-1:0] lut_word(input logic [4:0] bend, input logic [3:0] ofs);
    lut_word = {ofs, bend};
  endfunction

endpackage

// File: rtl/cclut_lut_loader_if.sv
// Configuration-bus side of the CCLUT loader: request strobes, read-back,
// status pulses and the write checksum.
interface cclut_lut_loader_if;

  logic                           cfg_wr;
  logic                           cfg_rd;
  logic [2:0]                     cfg_pid;
  logic [cclut_pkg::MXADRB-1:0]   cfg_adr;
  logic [cclut_pkg::MXDATB-1:0]   cfg_wdata;
  logic                           clr_start;
  logic [cclut_pkg::MXDATB-1:0]   cfg_rdata;
  logic                           cfg_ack;
  logic                           cfg_err;
  logic                           busy;
  logic                           clr_done;
  logic [15:0]                    cfg_cksum;

  modport master (
    output cfg_wr, cfg_rd, cfg_pid, cfg_adr, cfg_wdata, clr_start,
    input  cfg_rdata, cfg_ack, cfg_err, busy, clr_done, cfg_cksum
  );

  modport slave (
    input  cfg_wr, cfg_rd, cfg_pid, cfg_adr, cfg_wdata, clr_start,
    output cfg_rdata, cfg_ack, cfg_err, busy, clr_done, cfg_cksum
  );

endinterface

// File: rtl/cclut_lut_loader.sv
// Host-side writer / read-back / zero-fill sequencer for the CCLUT pattern RAMs.
// Optional running write checksum enabled by defining CCLUT_CKSUM_EN.
module cclut_lut_loader
  import cclut_pkg::*;
(
  input  logic                     clock,
  input  logic                     reset,
  cclut_lut_loader_if.slave        cfg,
  output logic [NPAT-1:0]          ram_we,
  output logic [MXADRB-1:0]        ram_adr,
  output logic [MXDATB-1:0]        ram_wdata,
  input  logic [NPAT*MXDATB-1:0]   ram_rdata
);

  state_t              r_state, w_state_nxt;
  logic [NPAT-1:0]     r_ram_we, w_we_nxt;
  logic [MXADRB-1:0]   r_ram_adr, w_adr_nxt;
  logic [MXDATB-1:0]   r_ram_wdata, w_wdata_nxt;
  logic [MXDATB-1:0]   r_rdata, w_rdata_nxt;
  logic [2:0]          r_pid, w_pid_nxt;
  logic                r_ack, w_ack_nxt;
  logic                r_err, w_err_nxt;
  logic                r_done, w_done_nxt;

  logic w_idle, w_pid_ok, w_take_clr, w_take_wr, w_take_rd, w_clr_last;

  // Request arbitration: clear beats write beats read; everything else is rejected
  assign w_idle     = (r_state == ST_IDLE);
  assign w_pid_ok   = (cfg.cfg_pid < 3'(NPAT));
  assign w_take_clr = w_idle & cfg.clr_start;
  assign w_take_wr  = w_idle & ~cfg.clr_start & cfg.cfg_wr & w_pid_ok;
  assign w_take_rd  = w_idle & ~cfg.clr_start & ~cfg.cfg_wr & cfg.cfg_rd & w_pid_ok;
  assign w_clr_last = (r_ram_adr == {MXADRB{1'b1}});

  always_comb begin
    if (w_idle)
      w_err_nxt = (cfg.clr_start & (cfg.cfg_wr | cfg.cfg_rd))
                | (~cfg.clr_start & cfg.cfg_wr & (cfg.cfg_rd | ~w_pid_ok))
                | (~cfg.clr_start & ~cfg.cfg_wr & cfg.cfg_rd & ~w_pid_ok);
    else
      w_err_nxt = cfg.clr_start | cfg.cfg_wr | cfg.cfg_rd;
  end

  always_ff @(posedge clock) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if      (w_take_clr) w_state_nxt = ST_CLEAR;
        else if (w_take_wr)  w_state_nxt = ST_WRITE;
        else if (w_take_rd)  w_state_nxt = ST_READ_ADR;
      end
      ST_WRITE:    w_state_nxt = ST_IDLE;
      ST_READ_ADR: w_state_nxt = ST_READ_CAP;
      ST_READ_CAP: w_state_nxt = ST_IDLE;
      ST_CLEAR:    if (w_clr_last) w_state_nxt = ST_IDLE;
      default:     w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_we_nxt    = '0;
    w_adr_nxt   = r_ram_adr;
    w_wdata_nxt = r_ram_wdata;
    w_rdata_nxt = r_rdata;
    w_pid_nxt   = r_pid;
    w_ack_nxt   = 1'b0;
    w_done_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_take_clr) begin
          w_we_nxt    = '1;
          w_adr_nxt   = '0;
          w_wdata_nxt = '0;
        end else if (w_take_wr) begin
          w_we_nxt    = NPAT'(1) << cfg.cfg_pid;
          w_adr_nxt   = cfg.cfg_adr;
          w_wdata_nxt = cfg.cfg_wdata;
          w_pid_nxt   = cfg.cfg_pid;
          w_ack_nxt   = 1'b1;
        end else if (w_take_rd) begin
          w_adr_nxt   = cfg.cfg_adr;
          w_pid_nxt   = cfg.cfg_pid;
        end
      end
      ST_READ_CAP: begin
        w_rdata_nxt = ram_rdata[32'(r_pid)*MXDATB +: MXDATB];
        w_ack_nxt   = 1'b1;
      end
      ST_CLEAR: begin
        if (w_clr_last) begin
          w_done_nxt = 1'b1;
        end else begin
          w_we_nxt  = '1;
          w_adr_nxt = r_ram_adr + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_ram_we    <= '0;
      r_ram_adr   <= '0;
      r_ram_wdata <= '0;
      r_rdata     <= '0;
      r_pid       <= '0;
      r_ack       <= 1'b0;
      r_err       <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_ram_we    <= w_we_nxt;
      r_ram_adr   <= w_adr_nxt;
      r_ram_wdata <= w_wdata_nxt;
      r_rdata     <= w_rdata_nxt;
      r_pid       <= w_pid_nxt;
      r_ack       <= w_ack_nxt;
      r_err       <= w_err_nxt;
      r_done      <= w_done_nxt;
    end
  end

`ifdef CCLUT_CKSUM_EN
  logic [15:0] r_cksum;

  // Accumulate once the write cycle has actually completed
  always_ff @(posedge clock) begin
    if (reset)                   r_cksum <= '0;
    else if (w_take_clr)         r_cksum <= '0;
    else if (r_state == ST_WRITE) r_cksum <= r_cksum + {4'b0, r_pid, r_ram_wdata};
  end

  assign cfg.cfg_cksum = r_cksum;
`else
  assign cfg.cfg_cksum = '0;
`endif

  assign ram_we        = r_ram_we;
  assign ram_adr       = r_ram_adr;
  assign ram_wdata     = r_ram_wdata;
  assign cfg.cfg_rdata = r_rdata;
  assign cfg.cfg_ack   = r_ack;
  assign cfg.cfg_err   = r_err;
  assign cfg.clr_done  = r_done;
  assign cfg.busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_cclut_lut_loader.sv
// Randomized self-checking bench for cclut_lut_loader with a behavioural RAM
// contents / checksum model and a simple one-cycle-latency RAM bank.
module tb_cclut_lut_loader;

  logic        clock = 1'b0;
  logic        reset;
  logic [4:0]  ram_we;
  logic [11:0] ram_adr;
  logic [8:0]  ram_wdata;
  logic [44:0] ram_rdata;

  cclut_lut_loader_if cfg_if();

  cclut_lut_loader dut (
    .clock     (clock),
    .reset     (reset),
    .cfg       (cfg_if),
    .ram_we    (ram_we),
    .ram_adr   (ram_adr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  always #5 clock = ~clock;

  // RAM bank the loader drives
  logic [8:0] tb_mem [5][4096];
  always @(posedge clock) begin
    for (int p = 0; p < 5; p++) begin
      ram_rdata[p*9 +: 9] <= tb_mem[p][ram_adr];
      if (ram_we[p]) tb_mem[p][ram_adr] <= ram_wdata;
    end
  end

  // Reference model: what each RAM should hold, last read-back, checksum
  logic [8:0]  exp_mem [5][4096];
  logic [8:0]  exp_rdata;
  logic [15:0] exp_ck;
  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic quiet();
    cfg_if.cfg_wr    = 1'b0;
    cfg_if.cfg_rd    = 1'b0;
    cfg_if.clr_start = 1'b0;
  endtask

  task automatic do_write(input logic [2:0] pid, input logic [11:0] adr,
                          input logic [8:0] data, input bit also_rd);
    bit ok;
    ok = (pid < 3'd5);
    cfg_if.cfg_wr = 1'b1; cfg_if.cfg_rd = also_rd;
    cfg_if.cfg_pid = pid; cfg_if.cfg_adr = adr; cfg_if.cfg_wdata = data;
    step();
    quiet();
    check("wr_err", cfg_if.cfg_err, (also_rd || !ok));
    if (ok) begin
      check("wr_we",   ram_we, 5'd1 << pid);
      check("wr_adr",  ram_adr, adr);
      check("wr_data", ram_wdata, data);
      check("wr_ack",  cfg_if.cfg_ack, 1'b1);
      check("wr_busy", cfg_if.busy, 1'b1);
      exp_mem[pid][adr] = data;
`ifdef CCLUT_CKSUM_EN
      exp_ck = exp_ck + {4'b0, pid, data};
`endif
    end else begin
      check("wr_bad_we",   ram_we, 5'd0);
      check("wr_bad_ack",  cfg_if.cfg_ack, 1'b0);
      check("wr_bad_busy", cfg_if.busy, 1'b0);
    end
    step();
    check("wr_end_we",   ram_we, 5'd0);
    check("wr_end_ack",  cfg_if.cfg_ack, 1'b0);
    check("wr_end_busy", cfg_if.busy, 1'b0);
    check("wr_cksum",    cfg_if.cfg_cksum, exp_ck);
  endtask

  task automatic do_read(input logic [2:0] pid, input logic [11:0] adr);
    cfg_if.cfg_rd = 1'b1; cfg_if.cfg_pid = pid; cfg_if.cfg_adr = adr;
    step();
    quiet();
    if (pid < 3'd5) begin
      check("rd_adr",  ram_adr, adr);
      check("rd_we",   ram_we, 5'd0);
      check("rd_busy", cfg_if.busy, 1'b1);
      check("rd_err",  cfg_if.cfg_err, 1'b0);
      step();
      check("rd_ack_early", cfg_if.cfg_ack, 1'b0);
      step();
      exp_rdata = exp_mem[pid][adr];
      check("rd_ack",   cfg_if.cfg_ack, 1'b1);
      check("rd_rdata", cfg_if.cfg_rdata, exp_rdata);
      step();
      check("rd_ack_end", cfg_if.cfg_ack, 1'b0);
      check("rd_hold",    cfg_if.cfg_rdata, exp_rdata);
    end else begin
      check("rd_bad_err",  cfg_if.cfg_err, 1'b1);
      check("rd_bad_busy", cfg_if.busy, 1'b0);
      step();
      check("rd_bad_ack",  cfg_if.cfg_ack, 1'b0);
      check("rd_bad_hold", cfg_if.cfg_rdata, exp_rdata);
    end
  endtask

  // Full clear with a concurrent write (dropped) and a read injected mid-way
  task automatic do_clear_full();
    int bad;
    bad = 0;
    cfg_if.clr_start = 1'b1; cfg_if.cfg_wr = 1'b1;
    cfg_if.cfg_pid = 3'd0; cfg_if.cfg_adr = 12'h005; cfg_if.cfg_wdata = 9'h055;
    step();
    quiet();
    check("clr_err_concurrent", cfg_if.cfg_err, 1'b1);
    check("clr_cksum_zero", cfg_if.cfg_cksum, 16'h0);
    for (int i = 0; i < 4096; i++) begin
      if (cfg_if.busy !== 1'b1 || ram_we !== 5'b11111 || ram_adr !== 12'(i) ||
          ram_wdata !== 9'h0 || cfg_if.clr_done !== 1'b0 ||
          cfg_if.cfg_err !== ((i == 0) || (i == 101)))
        bad++;
      if (i == 100) begin
        cfg_if.cfg_rd = 1'b1; cfg_if.cfg_pid = 3'd1;
      end
      step();
      quiet();
    end
    check("clr_bad_cycles", bad, 0);
    check("clr_done",       cfg_if.clr_done, 1'b1);
    check("clr_done_busy",  cfg_if.busy, 1'b0);
    check("clr_done_we",    ram_we, 5'd0);
    step();
    check("clr_done_end",   cfg_if.clr_done, 1'b0);
    for (int p = 0; p < 5; p++)
      for (int a = 0; a < 4096; a++) exp_mem[p][a] = 9'h0;
    exp_ck = 16'h0;
  endtask

  initial begin
    int bad;
    int guard;
    logic [2:0]  rp;
    logic [11:0] ra;
    logic [8:0]  rdv;
    quiet();
    cfg_if.cfg_pid = '0; cfg_if.cfg_adr = '0; cfg_if.cfg_wdata = '0;
    exp_rdata = 9'h0;
    exp_ck = 16'h0;
    reset = 1'b1;
    repeat (3) step();
    check("rst_we",    ram_we, 5'd0);
    check("rst_adr",   ram_adr, 12'd0);
    check("rst_wdata", ram_wdata, 9'd0);
    check("rst_rdata", cfg_if.cfg_rdata, 9'd0);
    check("rst_stat",  {cfg_if.cfg_ack, cfg_if.cfg_err, cfg_if.clr_done, cfg_if.busy}, 4'b0);
    check("rst_cksum", cfg_if.cfg_cksum, 16'h0);
    reset = 1'b0;
    step();

    // Directed write/read-back and invalid pid
    do_write(3'd2, 12'h0A5, 9'h1E7, 1'b0);
    do_read(3'd2, 12'h0A5);
    check("dir_rdata_1e7", cfg_if.cfg_rdata, 9'h1E7);
    do_write(3'd5, 12'h0A5, 9'h0AA, 1'b0);
    do_read(3'd7, 12'h001);

    do_clear_full();
    do_read(3'd4, 12'hFFF);
    do_read(3'd2, 12'h0A5);

    // Checksum pair
    do_write(3'd1, 12'h010, 9'h001, 1'b0);
    do_write(3'd3, 12'h020, 9'h1FF, 1'b0);
`ifdef CCLUT_CKSUM_EN
    check("cksum_pair", cfg_if.cfg_cksum, 16'h0A00);
`else
    check("cksum_tied", cfg_if.cfg_cksum, 16'h0);
`endif

    // Randomized traffic against the model
    for (int k = 0; k < 150; k++) begin
      rp  = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      ra  = 12'($urandom_range(0, 31));
      rdv = 9'($urandom);
      if ($urandom_range(0, 1) == 0)
        do_write(rp, ra, rdv, ($urandom_range(0, 9) == 0));
      else
        do_read(rp, ra);
    end

    // Reset in the middle of a clear
    do_write(3'd1, 12'h300, 9'h111, 1'b0);
    do_write(3'd1, 12'h500, 9'h122, 1'b0);
    cfg_if.clr_start = 1'b1;
    step();
    quiet();
    guard = 0;
    while (ram_adr !== 12'h400 && guard < 5000) begin
      step();
      guard++;
    end
    check("mid_clr_reach_400", ram_adr, 12'h400);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_rst_we",   ram_we, 5'd0);
    check("mid_rst_busy", cfg_if.busy, 1'b0);
    check("mid_rst_stat", {cfg_if.cfg_ack, cfg_if.clr_done}, 2'b0);
    for (int p = 0; p < 5; p++)
      for (int a = 0; a <= 12'h400; a++) exp_mem[p][a] = 9'h0;
    exp_ck = 16'h0;
    exp_rdata = 9'h0;
    do_write(3'd0, 12'h7FF, 9'h0C3, 1'b0);
    do_read(3'd1, 12'h300);
    do_read(3'd1, 12'h500);
    do_read(3'd0, 12'h7FF);
    bad = 0;
    for (int i = 0; i < 3200; i++) begin
      if (cfg_if.clr_done !== 1'b0 || ram_we !== 5'd0) bad++;
      step();
    end
    check("no_done_after_abort", bad, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
